// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the serial sequence-detector family and the pattern
// transmitter that drives it.
//   sd_state_t : transmitter FSM encodings (IDLE=0, SHIFT=1, PARITY=2). The
//                detector benches probe the transmitter's state port against
//                these values.
//   norm_len   : maps a requested pattern length onto the legal range 1..width
//                (0 or anything above width means "full width").
// -----------------------------------------------------------------------------
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PARITY = 3'd2
    } sd_state_t;

    function automatic int unsigned norm_len(input int unsigned len,
                                             input int unsigned width);
        if (len == 0 || len > width)
            return width;
        return len;
    endfunction

endpackage

// File: rtl/sd_piso_shift.sv
// -----------------------------------------------------------------------------
// sd_piso_shift
// Loadable MSB-first parallel-in/serial-out register with a bit down-counter.
// The loaded word must already be MSB-aligned: the first bit to send sits in
// bit [WIDTH-1]. After a load the register holds the bit currently on the
// line at its MSB; next_bit exposes the bit that follows it.
// Requires WIDTH >= 2.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears register/count)
//   load         : capture load_data / load_len (has priority over shift)
//   load_data    : MSB-aligned pattern word
//   load_len     : number of valid bits in load_data, 1..WIDTH
//   shift        : advance one bit
//   next_bit     : bit that will be on the line after the next shift
//   last         : the current bit is the final bit of the loaded word
//   penult       : the current bit is the second-to-last bit
// -----------------------------------------------------------------------------
module sd_piso_shift #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             shift,
    output logic             next_bit,
    output logic             last,
    output logic             penult
);

    logic [WIDTH-1:0] sreg;
    logic [LEN_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_data;
            cnt  <= load_len - LEN_W'(1);
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= cnt - LEN_W'(1);
        end
    end

    assign next_bit = sreg[WIDTH-2];
    assign last     = (cnt == '0);
    assign penult   = (cnt == LEN_W'(1));

endmodule

// File: rtl/sd_pattern_tx.sv
// -----------------------------------------------------------------------------
// sd_pattern_tx
// Serial pattern transmitter feeding the din of the sd1101 detector family.
// Accepts a pattern word over a valid/ready handshake and sends it MSB-first,
// one bit per clock, load_rep+1 times back-to-back with no gap bits. A new
// pattern can be accepted in the cycle carrying the final stream bit, so
// consecutive patterns also chain without an idle cycle.
//
// Optional build macro:
//   SD_PATTERN_TX_PARITY_EN : after the final repetition, append one even
//                             parity bit (XOR of the pattern bits) in state
//                             PARITY; done/load_ready move to that cycle.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load_valid  : a pattern is offered
//   load_ready  : pattern can be accepted this cycle (idle or final-bit cycle)
//   load_data   : pattern, bit [len-1] sent first, bit [0] last
//   load_len    : bits to send; 0 or > WIDTH means WIDTH
//   load_rep    : extra repetitions
//   dout        : serial bit (IDLE_LEVEL when dout_valid=0)
//   dout_valid  : dout carries a pattern/parity bit
//   done        : one-cycle pulse on the final stream bit
//   state       : FSM state for debug
// -----------------------------------------------------------------------------
module sd_pattern_tx
    import sd_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   LEN_W      = 4,
    parameter int   REP_W      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [REP_W-1:0] load_rep,
    output logic             dout,
    output logic             dout_valid,
    output logic             done,
    output logic [2:0]       state
);

`ifdef SD_PATTERN_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    sd_state_t        st;
    logic [WIDTH-1:0] pat_q;     // MSB-aligned copy, reloaded for each repetition
    logic [LEN_W-1:0] len_q;
    logic [REP_W-1:0] rep_cnt;
`ifdef SD_PATTERN_TX_PARITY_EN
    logic             par_q;
`endif

    logic [LEN_W-1:0] nlen;
    logic [LEN_W-1:0] shamt;
    logic [WIDTH-1:0] in_aligned;
    logic             accept;
    logic             reload;
    logic             ld_en;
    logic [WIDTH-1:0] ld_data;
    logic [LEN_W-1:0] ld_len;
    logic             sh_en;
    logic             next_bit;
    logic             last;
    logic             penult;
    logic             fin_start;
    logic             fin_shift;
    logic             fin_reload;

    // Left-align the offered pattern so its first bit lands in the MSB; the
    // unused high bits are shifted out and the low end fills with zeros, so
    // the XOR of the aligned word is the parity of just the len pattern bits.
    assign nlen       = LEN_W'(norm_len(32'(load_len), WIDTH));
    assign shamt      = LEN_W'(WIDTH) - nlen;
    assign in_aligned = load_data << shamt;

    assign accept  = load_valid && load_ready;
    assign reload  = (st == ST_SHIFT) && last && (rep_cnt != '0);
    assign ld_en   = accept || reload;
    assign ld_data = accept ? in_aligned : pat_q;
    assign ld_len  = accept ? nlen : len_q;
    assign sh_en   = (st == ST_SHIFT) && !last;

    // "Next cycle carries the final stream bit" for each way of leaving the
    // current cycle; with parity enabled the final bit is always the parity
    // bit, so none of these fire.
    assign fin_start  = !PAR_EN && (nlen == LEN_W'(1)) && (load_rep == '0);
    assign fin_shift  = !PAR_EN && penult && (rep_cnt == '0);
    assign fin_reload = !PAR_EN && (len_q == LEN_W'(1)) && (rep_cnt == REP_W'(1));

    sd_piso_shift #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (ld_en),
        .load_data (ld_data),
        .load_len  (ld_len),
        .shift     (sh_en),
        .next_bit  (next_bit),
        .last      (last),
        .penult    (penult)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= ST_IDLE;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
            rep_cnt    <= '0;
            pat_q      <= '0;
            len_q      <= '0;
`ifdef SD_PATTERN_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else if (accept) begin
            // Accept is only possible in IDLE or on the final stream bit, and
            // in both cases the new pattern's first bit goes out next cycle.
            st         <= ST_SHIFT;
            dout       <= in_aligned[WIDTH-1];
            dout_valid <= 1'b1;
            done       <= fin_start;
            load_ready <= fin_start;
            rep_cnt    <= load_rep;
            pat_q      <= in_aligned;
            len_q      <= nlen;
`ifdef SD_PATTERN_TX_PARITY_EN
            par_q      <= ^in_aligned;
`endif
        end else begin
            case (st)
                ST_SHIFT: begin
                    if (!last) begin
                        dout       <= next_bit;
                        dout_valid <= 1'b1;
                        done       <= fin_shift;
                        load_ready <= fin_shift;
                    end else if (rep_cnt != '0) begin
                        // Next repetition starts immediately from the saved copy.
                        rep_cnt    <= rep_cnt - REP_W'(1);
                        dout       <= pat_q[WIDTH-1];
                        dout_valid <= 1'b1;
                        done       <= fin_reload;
                        load_ready <= fin_reload;
                    end else begin
`ifdef SD_PATTERN_TX_PARITY_EN
                        st         <= ST_PARITY;
                        dout       <= par_q;
                        dout_valid <= 1'b1;
                        done       <= 1'b1;
                        load_ready <= 1'b1;
`else
                        st         <= ST_IDLE;
                        dout       <= IDLE_LEVEL;
                        dout_valid <= 1'b0;
                        done       <= 1'b0;
                        load_ready <= 1'b1;
`endif
                    end
                end
                default: begin
                    // IDLE, the end of PARITY, and illegal codes all settle here.
                    st         <= ST_IDLE;
                    dout       <= IDLE_LEVEL;
                    dout_valid <= 1'b0;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_sd_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_sd_pattern_tx
// Scoreboard bench for sd_pattern_tx. The driver offers patterns and, on each
// accept, queues the hand-written expected bit stream; a monitor pops one
// entry per valid output cycle and checks dout, done and state, and checks
// idle levels on every non-valid cycle.
// -----------------------------------------------------------------------------
module tb_sd_pattern_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data = '0;
    logic [3:0] load_len = '0;
    logic [3:0] load_rep = '0;
    logic       dout;
    logic       dout_valid;
    logic       done;
    logic [2:0] state;

    always #5 clk = ~clk;

    sd_pattern_tx #(
        .WIDTH      (8),
        .LEN_W      (4),
        .REP_W      (4),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_rep   (load_rep),
        .dout       (dout),
        .dout_valid (dout_valid),
        .done       (done),
        .state      (state)
    );

`ifdef SD_PATTERN_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic       b;
        logic       d;
        logic [2:0] s;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b0;
    int   run_len  = 0;
    int   max_run  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per valid cycle, idle levels otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (dout_valid === 1'b1) begin
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_bit: dout=%b with empty scoreboard (t=%0t)", dout, $time);
                    end else begin
                        e = q.pop_front();
                        check("dout", 32'(dout), 32'(e.b));
                        check("done", 32'(done), 32'(e.d));
                        check("state", 32'(state), 32'(e.s));
                        if (done === 1'b1) check("ready_with_done", 32'(load_ready), 32'd1);
                    end
                end else begin
                    run_len = 0;
                    check("idle_dout", 32'(dout), 32'd0);
                    check("idle_done", 32'(done), 32'd0);
                    check("idle_valid", 32'(dout_valid), 32'd0);
                end
            end
        end
    end

    // Offer a pattern (leaves load_valid high) and queue its expected bits:
    // bits[n-1] first; par is the hand-computed parity for the parity build.
    task automatic send(input logic [7:0] d, input logic [3:0] len, input logic [3:0] rep,
                        input logic [31:0] bits, input int n, input logic par);
        bit acc = 1'b0;
        int waited = 0;
        load_data  = d;
        load_len   = len;
        load_rep   = rep;
        load_valid = 1'b1;
        while (!acc && waited < 60) begin
            acc = (load_ready === 1'b1);
            @(posedge clk);
            #1;
            waited++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: pattern %h not accepted in %0d cycles", d, waited);
        end else begin
            for (int i = n - 1; i >= 0; i--)
                q.push_back('{b: bits[i], d: (i == 0) && !PAR, s: 3'd1});
            if (PAR) q.push_back('{b: par, d: 1'b1, s: 3'd2});
        end
    endtask

    task automatic release_valid();
        load_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (q.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        reset = 1'b0;
        mon_on = 1'b1;
        @(posedge clk);
        #1;

        // 1: 1101, single send
        send(8'b0000_1101, 4'd4, 4'd0, 32'b1101, 4, 1'b1);
        release_valid();
        drain("drain_t1");

        // 2: 1101 sent three times, no gaps
        max_run = 0;
        send(8'b0000_1101, 4'd4, 4'd2, 32'b1101_1101_1101, 12, 1'b1);
        release_valid();
        drain("drain_t2");
        check("t2_run", 32'(max_run), PAR ? 32'd13 : 32'd12);

        // 3: gapless chain 1101 then 101 (high garbage bits must be ignored)
        max_run = 0;
        send(8'b0000_1101, 4'd4, 4'd0, 32'b1101, 4, 1'b1);
        send(8'b1111_0101, 4'd3, 4'd0, 32'b101, 3, 1'b0);
        release_valid();
        drain("drain_t3");
        check("t3_run", 32'(max_run), PAR ? 32'd9 : 32'd7);

        // 4: reset during the 2nd bit of an 8-bit pattern
        send(8'hB3, 4'd8, 4'd0, 32'b1011_0011, 8, 1'b1);
        release_valid();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        check("abort_state", 32'(state), 32'd0);
        check("abort_valid", 32'(dout_valid), 32'd0);
        check("abort_ready", 32'(load_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        // 5: len=0 means full width; len>WIDTH likewise
        send(8'hA5, 4'd0, 4'd0, 32'b1010_0101, 8, 1'b0);
        release_valid();
        drain("drain_t5a");
        send(8'h3C, 4'd12, 4'd0, 32'b0011_1100, 8, 1'b0);
        release_valid();
        drain("drain_t5b");

        // 5c: len=1 single bit; done and ready on that same cycle
        send(8'h01, 4'd1, 4'd0, 32'b1, 1, 1'b1);
        release_valid();
        drain("drain_t5c");

        // Max repetitions of a single bit: 16 ones
        max_run = 0;
        send(8'hFF, 4'd1, 4'd15, 32'hFFFF, 16, 1'b1);
        release_valid();
        drain("drain_rep_max");
        check("rep_max_run", 32'(max_run), PAR ? 32'd17 : 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sd_pattern_tx.md
Name: sd_pattern_tx

Overview:
- Serial pattern transmitter: the driving end of the serial bit-stream interface (clk, reset, din) used by the sequence detectors (sd1101 family).
- Accepts a parallel pattern word with a valid/ready handshake and shifts it out MSB-first, one bit per clock, optionally repeated.
- Its dout connects directly to a detector's din, so detector benches and on-chip self-tests get cycle-exact, gapless stimulus instead of hand-timed din assignments.

Parameters:
- WIDTH, 8: maximum pattern length in bits.
- LEN_W, 4: width of load_len. Must satisfy 2^LEN_W > WIDTH.
- REP_W, 4: width of load_rep.
- IDLE_LEVEL, 1'b0: value driven on dout when no bit is being sent.

Ports:
- clk: input, 1. Rising-edge clock.
- reset: input, 1. Synchronous, active-high reset.
- load_valid: input, 1. A pattern is offered.
- load_ready: output, 1. The block can accept a pattern this cycle.
- load_data: input, WIDTH. Pattern; bit [len-1] is sent first, bit [0] last.
- load_len: input, LEN_W. Number of bits to send. 0 or any value > WIDTH means WIDTH.
- load_rep: input, REP_W. Extra repetitions; the pattern is sent load_rep+1 times back-to-back.
- dout: output, 1. Serial bit; connects to the detector's din.
- dout_valid: output, 1. dout carries a pattern bit this cycle.
- done: output, 1. One-cycle pulse on the final bit of the final repetition (or on the parity bit when parity is enabled).
- state: output, 3. FSM state, for debug and bench probing.

Behaviour:
- Reset: all registers are synchronous and take their reset values on the first clk edge with reset=1.
  - Reset values: state=IDLE (3'd0), dout=IDLE_LEVEL, dout_valid=0, done=0, load_ready=1.
  - Internal registers clear: shift register 0, bit counter 0, repeat counter 0.
- Reset mid-transfer aborts the transfer immediately. The next cycle shows the idle values and the pattern is discarded.
- Handshake: a pattern is accepted on the edge where load_valid && load_ready.
  - load_data, load_len and load_rep are sampled only on that edge.
  - The first bit appears on the registered dout in the cycle after acceptance, so latency is 1 clk.
- FSM states:
  - IDLE (0): load_ready=1. On accept, go to SHIFT.
  - SHIFT (1): dout_valid=1 and dout = current bit; one bit per clk.
    - After the last bit of a repetition with repetitions remaining: reload the saved pattern and stay in SHIFT. There is no gap bit.
    - After the last bit of the final repetition: go to PARITY if TX_PARITY_EN is defined, otherwise go to IDLE.
  - PARITY (2): exists only with TX_PARITY_EN. Drives one bit, then goes to IDLE.
  - Codes 3..7 are illegal and recover to IDLE on the next edge.
- Gapless chaining: load_ready is also 1 during the cycle that drives the final stream bit (the last pattern bit, or the parity bit).
  - An accept in that cycle starts the new pattern's first bit in the next cycle, in state SHIFT, with no idle cycle.
  - done still pulses for the old pattern.
- Outside the IDLE and final-bit cycles: load_ready=0, and load_valid is ignored.
- Counters:
  - The bit counter counts down from len-1 to 0.
  - The repeat counter counts down from load_rep to 0.
  - load_rep = 2^REP_W-1 gives the maximum of 2^REP_W sends. No wrap-around is permitted.
- len=1 sends a single bit per repetition. In that case done and load_ready coincide with the first data cycle of the final repetition.
- When dout_valid=0, dout = IDLE_LEVEL.

Optional Feature:
- Macro: SD_PATTERN_TX_PARITY_EN.
- When defined:
  - After the final repetition, one extra cycle in state PARITY drives dout = even parity (XOR) of the len pattern bits, with dout_valid=1.
  - Parity is computed once per pattern, not per repetition.
  - done and load_ready move to the parity cycle.
- When undefined: PARITY state, parity logic and parity cycle are absent.

Decomposition:
- Package sd_pkg holds:
  - state encodings ST_IDLE=3'd0, ST_SHIFT=3'd1, ST_PARITY=3'd2, shared with the detector benches;
  - a function that normalises the length (0 or >WIDTH becomes WIDTH).
- One natural sub-module: sd_piso_shift, a loadable MSB-first parallel-in/serial-out register with a down-counter and a last flag.
  - The top level holds the FSM, repeat counter, handshake and parity.

Test Plan:
1. Reset, then accept load_data=8'b0000_1101, len=4, rep=0.
   - Required: starting 1 clk after accept, dout=1,1,0,1 with dout_valid=1 for 4 cycles; done on the 4th cycle; then IDLE with dout=0.
   - Fed into sd1101_mealy_over, its dout pulses exactly once.
2. Pattern 1101, len=4, rep=2.
   - Required: 12 contiguous valid bits 110111011101 and a single done pulse on bit 12.
   - The overlapping detector pulses 3 times.
3. Gapless chain: hold load_valid with a second pattern 3'b101, len=3.
   - Required: the second pattern is accepted on the final-bit cycle of the first, and its bits follow with no idle cycle.
   - Total 7 valid cycles; done pulses at cycles 4 and 7.
4. Reset asserted at the 2nd bit of an 8-bit pattern.
   - Required: next cycle state=0, dout_valid=0, load_ready=1; no done pulse.
5. len=0 with WIDTH=8, data 8'hA5.
   - Required: 8 bits 10100101 are sent.
   - len=1, data bit0=1, rep=0: single bit 1, with done and load_ready in that same cycle.
6. With SD_PATTERN_TX_PARITY_EN, pattern 1101, len=4.
   - Required: bits 1,1,0,1, then parity bit 1 in state 2; done on the parity cycle; 5 valid cycles total.
